rf_dump: RTL and testbench

- Debug read-out engine for the 8x16 register file; it acts as the reader on the register file's combinational read port.
- On a start pulse it walks r0..r7 in order, driving the read select and sampling the returned data.
- Each register is presented on a valid/ready output stream tagged with its index, for the debug/trace path.
- Sits beside the datapath and drives one read port only. The core continues using the other read port and the write port.

---
 rtl/rf_dump_if.sv | 25 ++
 rtl/rf_dump.sv | 117 +++++++++++
 tb/tb_rf_dump.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_if.sv
// Debug dump output stream: one register value plus its index per beat,
// with a valid/ready handshake.
interface rf_dump_if #(
    parameter int SELW = 3,
    parameter int DW   = 16
);
    logic [DW-1:0]   dout;
    logic [SELW-1:0] dout_idx;
    logic            dout_valid;
    logic            dout_ready;

    modport master (
        output dout,
        output dout_idx,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_idx,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/rf_dump.sv
// Register-file debug dump: on start, walks r0..NREGS-1 over one read port
// and streams each value with its index on a valid/ready channel.
module rf_dump #(
    parameter int NREGS = 8,
    parameter int SELW  = 3,
    parameter int DW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [SELW-1:0] regsel_out,
    input  logic [DW-1:0]   regdata_in,
    rf_dump_if.master       dst,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [SELW-1:0] LAST_IDX = SELW'(NREGS - 1);

    state_t          state_q, state_d;
    logic [SELW-1:0] idx_q, idx_d;
    logic            hs;
    logic            cap;
    logic            drop;

    assign hs = dst.dout_valid && dst.dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // abort outranks the handshake, so an aborted word is never counted as sent
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap     = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (abort) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    cap     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    drop    = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (hs) begin
                    drop = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + SELW'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dst.dout       <= '0;
            dst.dout_idx   <= '0;
            dst.dout_valid <= 1'b0;
            err            <= 1'b0;
        end else begin
            if (cap) begin
                dst.dout       <= regdata_in;
                dst.dout_idx   <= idx_q;
                dst.dout_valid <= 1'b1;
            end else if (drop) begin
                dst.dout_valid <= 1'b0;
            end
            err <= start && (state_q != IDLE);
        end
    end

    // Read select is only meaningful in READ; park it at 0 otherwise.
    assign regsel_out = (state_q == READ) ? idx_q : '0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump with a behavioural 8x16 register file on the read port.
module tb_rf_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  regsel_out;
    logic [15:0] regdata_in;
    logic        busy, done, err;

    int tests_run = 0;
    int fails = 0;

    rf_dump_if #(.SELW(3), .DW(16)) sif ();

    rf_dump #(.NREGS(8), .SELW(3), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .regsel_out(regsel_out),
        .regdata_in(regdata_in),
        .dst       (sif.master),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [15:0] rf [8];
    always_comb regdata_in = rf[regsel_out];

    logic [2:0]  q_idx [$];
    logic [15:0] q_dat [$];
    int          q_cyc [$];
    int          n_err, n_done, done_cyc, stall_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) rf[i] = 16'(16'h1000 + i);
    endtask

    // Gathers one dump; c counts samples taken #1 after each edge following the start edge.
    task automatic collect(input bit do_start, input int stall_idx, input int repulse_idx,
                           input int wr_idx, input int budget);
        bit          stalled = 0, repulsed = 0, written = 0;
        logic [18:0] held;
        q_idx.delete(); q_dat.delete(); q_cyc.delete();
        n_err = 0; n_done = 0; done_cyc = -1; stall_bad = 0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int c = 0; c < budget; c++) begin
            if (err) n_err++;
            if (done) begin
                n_done++;
                done_cyc = c;
                break;
            end
            if (sif.dout_valid) begin
                if (int'(sif.dout_idx) == stall_idx && !stalled) begin
                    held = {sif.dout_idx, sif.dout};
                    stalled = 1;
                    sif.dout_ready = 1'b0;
                    repeat (5) begin
                        tick();
                        if (err) n_err++;
                        if (!sif.dout_valid || {sif.dout_idx, sif.dout} !== held) stall_bad++;
                    end
                    sif.dout_ready = 1'b1;
                end
                if (int'(sif.dout_idx) == repulse_idx && !repulsed) begin
                    start = 1'b1;
                    repulsed = 1;
                end
                if (int'(sif.dout_idx) == wr_idx && !written) begin
                    rf[5] = 16'hBEEF;
                    rf[1] = 16'h0BAD;
                    written = 1;
                end
                q_idx.push_back(sif.dout_idx);
                q_dat.push_back(sif.dout);
                q_cyc.push_back(c);
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({regsel_out, sif.dout, sif.dout_idx, sif.dout_valid, busy, done, err} !== 25'd0)
            begin fails++; $display("FAIL reset_outputs: got sel=%0d dout=%h idx=%0d v=%b busy=%b done=%b err=%b, expected all 0",
                regsel_out, sif.dout, sif.dout_idx, sif.dout_valid, busy, done, err); end
        tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0 || sif.dout_valid !== 1'b0)
            begin fails++; $display("FAIL reset_idle: got busy=%b v=%b, expected 0 0", busy, sif.dout_valid); end
    endtask

    task automatic test_full_dump();
        preload();
        sif.dout_ready = 1'b1;
        collect(1, -1, -1, -1, 100);
        tests_run++;
        if (n_done !== 1 || done_cyc !== 16)
            begin fails++; $display("FAIL full_done: got n_done=%0d at cyc %0d, expected 1 at 16", n_done, done_cyc); end
        tests_run++;
        if (q_idx.size() !== 8)
            begin fails++; $display("FAIL full_count: got %0d words, expected 8", q_idx.size()); end
        for (int k = 0; k < q_idx.size(); k++) begin
            tests_run++;
            if (q_idx[k] !== 3'(k) || q_dat[k] !== 16'(16'h1000 + k) || q_cyc[k] !== 2 * k + 1)
                begin fails++; $display("FAIL full_word%0d: got idx=%0d dat=%h cyc=%0d, expected idx=%0d dat=%h cyc=%0d",
                    k, q_idx[k], q_dat[k], q_cyc[k], k, 16'(16'h1000 + k), 2 * k + 1); end
        end
        tests_run++;
        if (n_err !== 0)
            begin fails++; $display("FAIL full_err: got %0d err cycles, expected 0", n_err); end
        tests_run++;
        if (busy !== 1'b1)
            begin fails++; $display("FAIL full_busy_in_done: got %b, expected 1", busy); end
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin fails++; $display("FAIL full_busy_fall: got busy=%b done=%b, expected 0 0", busy, done); end
    endtask

    task automatic test_stall();
        preload();
        sif.dout_ready = 1'b1;
        collect(1, 3, -1, -1, 100);
        tests_run++;
        if (stall_bad !== 0)
            begin fails++; $display("FAIL stall_hold: got %0d unstable cycles, expected 0", stall_bad); end
        tests_run++;
        if (q_idx.size() !== 8 || n_done !== 1)
            begin fails++; $display("FAIL stall_count: got %0d words done=%0d, expected 8 words done=1", q_idx.size(), n_done); end
        for (int k = 0; k < q_idx.size(); k++) begin
            tests_run++;
            if (q_idx[k] !== 3'(k) || q_dat[k] !== 16'(16'h1000 + k))
                begin fails++; $display("FAIL stall_word%0d: got idx=%0d dat=%h, expected idx=%0d dat=%h",
                    k, q_idx[k], q_dat[k], k, 16'(16'h1000 + k)); end
        end
        tick();
    endtask

    task automatic test_start_busy();
        preload();
        sif.dout_ready = 1'b1;
        collect(1, -1, 2, -1, 100);
        tests_run++;
        if (n_err !== 1)
            begin fails++; $display("FAIL busy_err: got %0d err cycles, expected 1", n_err); end
        tests_run++;
        if (q_idx.size() !== 8 || n_done !== 1 || done_cyc !== 16)
            begin fails++; $display("FAIL busy_count: got %0d words done=%0d cyc=%0d, expected 8 1 16", q_idx.size(), n_done, done_cyc); end
        for (int k = 0; k < q_idx.size(); k++) begin
            tests_run++;
            if (q_idx[k] !== 3'(k) || q_dat[k] !== 16'(16'h1000 + k))
                begin fails++; $display("FAIL busy_word%0d: got idx=%0d dat=%h, expected idx=%0d dat=%h",
                    k, q_idx[k], q_dat[k], k, 16'(16'h1000 + k)); end
        end
        tick();
    endtask

    task automatic test_abort();
        bit found = 0;
        int stray = 0;
        preload();
        sif.dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sif.dout_valid && sif.dout_idx == 3'd4) begin
                found = 1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!found)
            begin fails++; $display("FAIL abort_reach: got no word idx 4 within 40 cycles, expected one"); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (sif.dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin fails++; $display("FAIL abort_next: got v=%b busy=%b done=%b, expected 0 0 0", sif.dout_valid, busy, done); end
        repeat (3) begin
            tick();
            if (done || busy || sif.dout_valid) stray++;
        end
        tests_run++;
        if (stray !== 0)
            begin fails++; $display("FAIL abort_quiet: got %0d active cycles, expected 0", stray); end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b1)
            begin fails++; $display("FAIL abort_start_wins: got busy=%b, expected 1", busy); end
        collect(0, -1, -1, -1, 100);
        tests_run++;
        if (q_idx.size() !== 8 || n_done !== 1)
            begin fails++; $display("FAIL abort_redump_count: got %0d words done=%0d, expected 8 1", q_idx.size(), n_done); end
        for (int k = 0; k < q_idx.size(); k++) begin
            tests_run++;
            if (q_idx[k] !== 3'(k) || q_dat[k] !== 16'(16'h1000 + k))
                begin fails++; $display("FAIL abort_word%0d: got idx=%0d dat=%h, expected idx=%0d dat=%h",
                    k, q_idx[k], q_dat[k], k, 16'(16'h1000 + k)); end
        end
        tick();
    endtask

    task automatic test_write_during_dump();
        preload();
        sif.dout_ready = 1'b1;
        collect(1, -1, -1, 2, 100);
        tests_run++;
        if (q_idx.size() !== 8)
            begin fails++; $display("FAIL wr_count: got %0d words, expected 8", q_idx.size()); end
        else begin
            tests_run++;
            if (q_dat[5] !== 16'hBEEF)
                begin fails++; $display("FAIL wr_late_reg5: got %h, expected beef", q_dat[5]); end
            tests_run++;
            if (q_dat[1] !== 16'h1001)
                begin fails++; $display("FAIL wr_early_reg1: got %h, expected 1001", q_dat[1]); end
            tests_run++;
            if (q_dat[2] !== 16'h1002 || q_dat[6] !== 16'h1006)
                begin fails++; $display("FAIL wr_others: got r2=%h r6=%h, expected 1002 1006", q_dat[2], q_dat[6]); end
        end
        tick();
    endtask

    task automatic test_async_reset();
        int stray = 0;
        preload();
        sif.dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (sif.dout_valid !== 1'b1 || sif.dout !== 16'h1001)
            begin fails++; $display("FAIL arst_pre: got v=%b dout=%h, expected 1 1001", sif.dout_valid, sif.dout); end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({regsel_out, sif.dout, sif.dout_idx, sif.dout_valid, busy, done, err} !== 25'd0)
            begin fails++; $display("FAIL arst_outputs: got sel=%0d dout=%h idx=%0d v=%b busy=%b done=%b err=%b, expected all 0",
                regsel_out, sif.dout, sif.dout_idx, sif.dout_valid, busy, done, err); end
        tick();
        rst = 1'b1;
        repeat (5) begin
            tick();
            if (busy || sif.dout_valid || regsel_out != 3'd0 || done) stray++;
        end
        tests_run++;
        if (stray !== 0)
            begin fails++; $display("FAIL arst_quiet: got %0d active cycles, expected 0", stray); end
        collect(1, -1, -1, -1, 100);
        tests_run++;
        if (q_idx.size() !== 8 || n_done !== 1 || q_dat[0] !== 16'h1000)
            begin fails++; $display("FAIL arst_redump: got %0d words done=%0d, expected 8 1 starting at 1000", q_idx.size(), n_done); end
        tick();
    endtask

    initial begin
        sif.dout_ready = 1'b1;
        preload();
        test_reset();
        test_full_dump();
        test_stall();
        test_start_busy();
        test_abort();
        test_write_during_dump();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
